// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel word multiplexer.
// A channel is chosen either directly from SEL or by an automatic scan that
// dwells DWELL enabled cycles on each channel. OUT, CANAL and the change
// strobe troca are all registered, so no input reaches an output combinationally.
module mux_scan_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1000,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]          SEL,
    input  logic                      modo,
    input  logic                      enable,
    output logic [WIDTH-1:0]          OUT,
    output logic [SEL_W-1:0]          CANAL,
    output logic                      troca
);

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] canal_q, canal_nx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             troca_q, troca_d;
    logic             canal_oor;
    logic [WIDTH-1:0] ch_word [CHANNELS];

    // Unpack the flat input bus into one word per channel.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_word[k] = D[k*WIDTH +: WIDTH];
    end

    // CANAL can only be out of range after a direct SEL >= CHANNELS; the
    // extra leading zero keeps the compare meaningful for power-of-2 sizes.
    assign canal_oor = {1'b0, canal_q} > {1'b0, LAST_CH};

    // Next channel and next dwell count for the current mode.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        canal_nx = canal_q;
        cnt_d    = cnt_q;
        if (modo) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d    = '0;
                canal_nx = (canal_q == LAST_CH) ? '0 : canal_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Scanning never continues from an index with no channel behind it.
            if (canal_oor) begin
                canal_nx = '0;
            end
        end else begin
            canal_nx = SEL;
            cnt_d    = '0;
        end
    end

    // Word for the next channel; an index with no channel behind it reads as zero.
    always_comb begin
        out_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (canal_nx == SEL_W'(k)) begin
                out_d = ch_word[k];
            end
        end
        troca_d = (canal_nx != canal_q);
    end

    // State registers: update together when enabled, otherwise hold and drop the strobe.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            out_q   <= '0;
            canal_q <= '0;
            cnt_q   <= '0;
            troca_q <= 1'b0;
        end else if (enable) begin
            out_q   <= out_d;
            canal_q <= canal_nx;
            cnt_q   <= cnt_d;
            troca_q <= troca_d;
        end else begin
            troca_q <= 1'b0;
        end
    end

    assign OUT   = out_q;
    assign CANAL = canal_q;
    assign troca = troca_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: self-checking bench for mux_scan_n.
// Three instances: A (4 ch, dwell 3), B (3 ch, dwell 4, non-power-of-2),
// C (4 ch, dwell 4). Directed scenarios use values from the channel/dwell
// rules; a randomized run on A is compared against a cycle-level model.
module tb_mux_scan_n;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    // Instance A: 4 channels, dwell 3
    logic [31:0] d_a;
    logic [1:0]  sel_a;
    logic        modo_a, en_a;
    logic [7:0]  out_a;
    logic [1:0]  canal_a;
    logic        troca_a;

    // Instance B: 3 channels, dwell 4
    logic [23:0] d_b;
    logic [1:0]  sel_b;
    logic        modo_b, en_b;
    logic [7:0]  out_b;
    logic [1:0]  canal_b;
    logic        troca_b;

    // Instance C: 4 channels, dwell 4
    logic [31:0] d_c;
    logic [1:0]  sel_c;
    logic        modo_c, en_c;
    logic [7:0]  out_c;
    logic [1:0]  canal_c;
    logic        troca_c;

    mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) u_a (
        .clock(clock), .reset(reset), .D(d_a), .SEL(sel_a), .modo(modo_a),
        .enable(en_a), .OUT(out_a), .CANAL(canal_a), .troca(troca_a)
    );

    mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL(4)) u_b (
        .clock(clock), .reset(reset), .D(d_b), .SEL(sel_b), .modo(modo_b),
        .enable(en_b), .OUT(out_b), .CANAL(canal_b), .troca(troca_b)
    );

    mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u_c (
        .clock(clock), .reset(reset), .D(d_c), .SEL(sel_c), .modo(modo_c),
        .enable(en_c), .OUT(out_c), .CANAL(canal_c), .troca(troca_c)
    );

    function automatic logic [7:0] word4(input logic [31:0] d, input int k);
        return d[k*8 +: 8];
    endfunction

    function automatic logic [7:0] word3(input logic [23:0] d, input int k);
        return d[k*8 +: 8];
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int exp_ch;
        d_a = 32'h44332211; sel_a = 2'd0; modo_a = 1'b1; en_a = 1'b1;
        tick();
        checks++; if (out_a !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", out_a); end
        checks++; if (canal_a !== 2'd0) begin failures++; $display("FAIL reset_canal got=%0d exp=0", canal_a); end
        checks++; if (troca_a !== 1'b0) begin failures++; $display("FAIL reset_troca got=%b exp=0", troca_a); end
        reset = 1'b0;
        // Scan 7 edges: CANAL=2 with the dwell counter at 1.
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp_ch = (e / 3) % 4;
            checks++; if (canal_a !== 2'(exp_ch)) begin failures++; $display("FAIL reset_prescan_canal e=%0d got=%0d exp=%0d", e, canal_a, exp_ch); end
        end
        // Asynchronous assertion between edges.
        #2 reset = 1'b1;
        #1;
        checks++; if (out_a !== 8'h00) begin failures++; $display("FAIL reset_async_out got=%h exp=00", out_a); end
        checks++; if (canal_a !== 2'd0) begin failures++; $display("FAIL reset_async_canal got=%0d exp=0", canal_a); end
        checks++; if (troca_a !== 1'b0) begin failures++; $display("FAIL reset_async_troca got=%b exp=0", troca_a); end
        #1 reset = 1'b0;
        // First advance comes on the 3rd enabled edge after release.
        for (int e = 1; e <= 3; e++) begin
            tick();
            checks++; if (canal_a !== ((e == 3) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL reset_release_canal e=%0d got=%0d", e, canal_a); end
            checks++; if (troca_a !== (e == 3)) begin failures++; $display("FAIL reset_release_troca e=%0d got=%b", e, troca_a); end
        end
    endtask

    task automatic test_direct();
        modo_a = 1'b0; sel_a = 2'd0; d_a = 32'h44332211;
        tick();
        checks++; if (out_a !== 8'h11) begin failures++; $display("FAIL direct_sel0_out got=%h exp=11", out_a); end
        checks++; if (canal_a !== 2'd0) begin failures++; $display("FAIL direct_sel0_canal got=%0d exp=0", canal_a); end
        tick();
        checks++; if (troca_a !== 1'b0) begin failures++; $display("FAIL direct_same_sel_troca got=%b exp=0", troca_a); end
        sel_a = 2'd2;
        tick();
        checks++; if (out_a !== 8'h33) begin failures++; $display("FAIL direct_sel2_out got=%h exp=33", out_a); end
        checks++; if (canal_a !== 2'd2) begin failures++; $display("FAIL direct_sel2_canal got=%0d exp=2", canal_a); end
        checks++; if (troca_a !== 1'b1) begin failures++; $display("FAIL direct_sel2_troca got=%b exp=1", troca_a); end
        tick();
        checks++; if (troca_a !== 1'b0) begin failures++; $display("FAIL direct_hold_troca got=%b exp=0", troca_a); end
        d_a[23:16] = 8'hA5;
        tick();
        checks++; if (out_a !== 8'hA5) begin failures++; $display("FAIL direct_live_out got=%h exp=a5", out_a); end
        checks++; if (troca_a !== 1'b0) begin failures++; $display("FAIL direct_live_troca got=%b exp=0", troca_a); end
    endtask

    task automatic test_scan_wrap();
        int exp_ch;
        modo_a = 1'b0; sel_a = 2'd0;
        tick();
        checks++; if (canal_a !== 2'd0) begin failures++; $display("FAIL scan_start_canal got=%0d exp=0", canal_a); end
        modo_a = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            d_a = $urandom;
            tick();
            exp_ch = (e / 3) % 4;
            checks++; if (canal_a !== 2'(exp_ch)) begin failures++; $display("FAIL scan_canal e=%0d got=%0d exp=%0d", e, canal_a, exp_ch); end
            checks++; if (troca_a !== (e % 3 == 0)) begin failures++; $display("FAIL scan_troca e=%0d got=%b", e, troca_a); end
            checks++; if (out_a !== word4(d_a, exp_ch)) begin failures++; $display("FAIL scan_out e=%0d got=%h exp=%h", e, out_a, word4(d_a, exp_ch)); end
        end
    endtask

    task automatic test_enable_hold();
        logic [7:0] hold_out;
        tick();
        checks++; if (canal_a !== 2'd0) begin failures++; $display("FAIL hold_pre_canal got=%0d exp=0", canal_a); end
        hold_out = word4(d_a, 0);
        en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d_a = $urandom;
            tick();
            checks++; if (canal_a !== 2'd0) begin failures++; $display("FAIL hold_canal i=%0d got=%0d exp=0", i, canal_a); end
            checks++; if (out_a !== hold_out) begin failures++; $display("FAIL hold_out i=%0d got=%h exp=%h", i, out_a, hold_out); end
            checks++; if (troca_a !== 1'b0) begin failures++; $display("FAIL hold_troca i=%0d got=%b exp=0", i, troca_a); end
        end
        en_a = 1'b1;
        d_a = $urandom;
        tick();
        checks++; if (canal_a !== 2'd0) begin failures++; $display("FAIL hold_resume1_canal got=%0d exp=0", canal_a); end
        checks++; if (out_a !== word4(d_a, 0)) begin failures++; $display("FAIL hold_resume1_out got=%h exp=%h", out_a, word4(d_a, 0)); end
        tick();
        checks++; if (canal_a !== 2'd1) begin failures++; $display("FAIL hold_resume2_canal got=%0d exp=1", canal_a); end
        checks++; if (troca_a !== 1'b1) begin failures++; $display("FAIL hold_resume2_troca got=%b exp=1", troca_a); end
        checks++; if (out_a !== word4(d_a, 1)) begin failures++; $display("FAIL hold_resume2_out got=%h exp=%h", out_a, word4(d_a, 1)); end
    endtask

    task automatic test_out_of_range();
        d_b = 24'hCCBBAA; modo_b = 1'b0; sel_b = 2'd3; en_b = 1'b1;
        tick();
        checks++; if (out_b !== 8'h00) begin failures++; $display("FAIL oor_out got=%h exp=00", out_b); end
        checks++; if (canal_b !== 2'd3) begin failures++; $display("FAIL oor_canal got=%0d exp=3", canal_b); end
        checks++; if (troca_b !== 1'b1) begin failures++; $display("FAIL oor_troca got=%b exp=1", troca_b); end
        modo_b = 1'b1;
        tick();
        checks++; if (canal_b !== 2'd0) begin failures++; $display("FAIL oor_scan_canal got=%0d exp=0", canal_b); end
        checks++; if (out_b !== word3(d_b, 0)) begin failures++; $display("FAIL oor_scan_out got=%h exp=%h", out_b, word3(d_b, 0)); end
        checks++; if (troca_b !== 1'b1) begin failures++; $display("FAIL oor_scan_troca got=%b exp=1", troca_b); end
        modo_b = 1'b0; sel_b = 2'd2;
        tick();
        checks++; if (out_b !== 8'hCC) begin failures++; $display("FAIL oor_last_out got=%h exp=cc", out_b); end
        en_b = 1'b0;
    endtask

    task automatic test_mode_switch();
        d_c = $urandom; modo_c = 1'b1; sel_c = 2'd0; en_c = 1'b1;
        for (int e = 1; e <= 12; e++) tick();
        checks++; if (canal_c !== 2'd3) begin failures++; $display("FAIL mode_pre_canal got=%0d exp=3", canal_c); end
        modo_c = 1'b0; sel_c = 2'd1;
        tick();
        checks++; if (canal_c !== 2'd1) begin failures++; $display("FAIL mode_direct_canal got=%0d exp=1", canal_c); end
        checks++; if (troca_c !== 1'b1) begin failures++; $display("FAIL mode_direct_troca got=%b exp=1", troca_c); end
        checks++; if (out_c !== word4(d_c, 1)) begin failures++; $display("FAIL mode_direct_out got=%h exp=%h", out_c, word4(d_c, 1)); end
        modo_c = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++; if (canal_c !== ((e == 4) ? 2'd2 : 2'd1)) begin failures++; $display("FAIL mode_rescan_canal e=%0d got=%0d", e, canal_c); end
            checks++; if (troca_c !== (e == 4)) begin failures++; $display("FAIL mode_rescan_troca e=%0d got=%b", e, troca_c); end
        end
        en_c = 1'b0;
    endtask

    // Randomized run on A against a model tracking channel and enabled-cycles-on-channel.
    task automatic test_random();
        int         m_ch, m_elapsed, nx;
        logic [7:0] m_out;
        logic       m_troca;
        modo_a = 1'b0; sel_a = 2'd0; en_a = 1'b1; d_a = $urandom;
        tick();
        m_ch = 0; m_elapsed = 0; m_out = word4(d_a, 0); m_troca = 1'b0;
        modo_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(9) == 0) modo_a = ~modo_a;
            en_a  = ($urandom_range(6) != 0);
            sel_a = 2'($urandom);
            d_a   = $urandom;
            tick();
            if (en_a) begin
                if (modo_a) begin
                    m_elapsed++;
                    if (m_elapsed == 3) begin
                        m_elapsed = 0;
                        nx = (m_ch + 1) % 4;
                    end else begin
                        nx = m_ch;
                    end
                end else begin
                    m_elapsed = 0;
                    nx = int'(sel_a);
                end
                m_troca = (nx != m_ch);
                m_ch    = nx;
                m_out   = word4(d_a, m_ch);
            end else begin
                m_troca = 1'b0;
            end
            checks++; if (canal_a !== 2'(m_ch)) begin failures++; $display("FAIL rand_canal i=%0d got=%0d exp=%0d", i, canal_a, m_ch); end
            checks++; if (out_a !== m_out) begin failures++; $display("FAIL rand_out i=%0d got=%h exp=%h", i, out_a, m_out); end
            checks++; if (troca_a !== m_troca) begin failures++; $display("FAIL rand_troca i=%0d got=%b exp=%b", i, troca_a, m_troca); end
        end
    endtask

    initial begin
        d_a = '0; sel_a = '0; modo_a = 1'b0; en_a = 1'b0;
        d_b = '0; sel_b = '0; modo_b = 1'b0; en_b = 1'b0;
        d_c = '0; sel_c = '0; modo_c = 1'b0; en_c = 1'b0;
        test_reset();
        test_direct();
        test_scan_wrap();
        test_enable_hold();
        test_out_of_range();
        test_mode_switch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
